// File: rtl/ecc_apb_slave_if.sv
// ecc_apb_slave_if: APB bus bundle between a master and ecc_apb_slave.
// Signal names follow the AMBA APB pin names.
interface ecc_apb_slave_if #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20
);
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic [AMBA_WORD-1:0]       PRDATA;
  logic                       PREADY;
  logic                       PSLVERR;

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/ecc_apb_slave.sv
// ecc_apb_slave: APB register bank and start strobe for the ECC controller.
// Define ECC_APB_PSLVERR_EN to flag unmapped, read-only and bad-mode accesses.
module ecc_apb_slave #(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  ecc_apb_slave_if.slave        apb,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic [1:0]            num_of_errors,
  input  logic                  operation_done,
  output logic [AMBA_WORD-1:0]  CTRL,
  output logic [AMBA_WORD-1:0]  DATA_IN,
  output logic [AMBA_WORD-1:0]  CODEWORD_WIDTH,
  output logic [AMBA_WORD-1:0]  NOISE,
  output logic                  CTRL_ready
);

  typedef enum logic [1:0] {
    FULL_IDLE   = 2'b00,
    FULL_SETUP  = 2'b01,
    FULL_ACCESS = 2'b10
  } state_e;

  state_e               state_q, state_d;
  logic [AMBA_WORD-1:0] ctrl_q, ctrl_d;
  logic [AMBA_WORD-1:0] din_q, din_d;
  logic [AMBA_WORD-1:0] cw_q, cw_d;
  logic [AMBA_WORD-1:0] noise_q, noise_d;
  logic [AMBA_WORD-1:0] dout_q, dout_d;
  logic [AMBA_WORD-1:0] prdata_q, prdata_d;
  logic [1:0]           nerr_q, nerr_d;
  logic                 busy_q, busy_d;
  logic                 ctrl_ready_q, ctrl_ready_d;

  logic [2:0]           addr;
  logic                 setup_ph;
  logic                 access_ph;
  logic                 pready;
  logic                 pslverr;
  logic                 wr_fire;
  logic                 start;
  logic [AMBA_WORD-1:0] rdata;
  logic                 unused_paddr;

  assign addr      = apb.PADDR[4:2];
  assign setup_ph  = apb.PSEL & ~apb.PENABLE;
  assign access_ph = apb.PSEL & apb.PENABLE;
  assign wr_fire   = access_ph & apb.PWRITE & pready;
  assign start     = wr_fire & (addr == 3'd0)
                   & (apb.PWDATA[1:0] != 2'b11);

  assign unused_paddr = ^{apb.PADDR[AMBA_ADDR_WIDTH-1:5],
                          apb.PADDR[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FULL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = FULL_IDLE;
    case (state_q)
      FULL_IDLE: begin
        state_d = setup_ph ? FULL_SETUP : FULL_IDLE;
      end
      FULL_SETUP: begin
        state_d = FULL_ACCESS;
      end
      FULL_ACCESS: begin
        if (!pready) begin
          state_d = FULL_ACCESS;
        end else if (setup_ph) begin
          state_d = FULL_SETUP;
        end else begin
          state_d = FULL_IDLE;
        end
      end
      default: begin
        state_d = FULL_IDLE;
      end
    endcase
  end

  // Only writes wait on busy; reads always finish in the first access cycle.
  always_comb begin
    pready  = 1'b0;
    pslverr = 1'b0;
    if (state_q == FULL_ACCESS) begin
      pready = ~apb.PWRITE | ~busy_q;
`ifdef ECC_APB_PSLVERR_EN
      pslverr = pready
              & ((addr[2:1] == 2'b11)
              | (apb.PWRITE & (addr[2:1] == 2'b10))
              | (apb.PWRITE & (addr == 3'd0)
                 & (apb.PWDATA[1:0] == 2'b11)));
`endif
    end
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    din_d   = din_q;
    cw_d    = cw_q;
    noise_d = noise_q;
    if (wr_fire) begin
      case (addr)
        3'd0:    ctrl_d  = apb.PWDATA;
        3'd1:    din_d   = apb.PWDATA;
        3'd2:    cw_d    = apb.PWDATA;
        3'd3:    noise_d = apb.PWDATA;
        default: ;
      endcase
    end
  end

  // A start in the same cycle as a stray done wins, leaving busy set.
  always_comb begin
    ctrl_ready_d = start;
    busy_d       = busy_q;
    if (operation_done) begin
      busy_d = 1'b0;
    end
    if (start) begin
      busy_d = 1'b1;
    end
    dout_d = dout_q;
    nerr_d = nerr_q;
    if (operation_done) begin
      dout_d = AMBA_WORD'(data_out);
      nerr_d = num_of_errors;
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      addr == 3'd0: rdata = ctrl_q;
      addr == 3'd1: rdata = din_q;
      addr == 3'd2: rdata = cw_q;
      addr == 3'd3: rdata = noise_q;
      addr == 3'd4: rdata = dout_q;
      addr == 3'd5: rdata = AMBA_WORD'(nerr_q);
      default:      rdata = '0;
    endcase
  end

  assign prdata_d = (state_q == FULL_SETUP) ? rdata : prdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q       <= '0;
      din_q        <= '0;
      cw_q         <= '0;
      noise_q      <= '0;
      dout_q       <= '0;
      nerr_q       <= '0;
      prdata_q     <= '0;
      busy_q       <= 1'b0;
      ctrl_ready_q <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      din_q        <= din_d;
      cw_q         <= cw_d;
      noise_q      <= noise_d;
      dout_q       <= dout_d;
      nerr_q       <= nerr_d;
      prdata_q     <= prdata_d;
      busy_q       <= busy_d;
      ctrl_ready_q <= ctrl_ready_d;
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready;
  assign apb.PSLVERR = pslverr;

  assign CTRL           = ctrl_q;
  assign DATA_IN        = din_q;
  assign CODEWORD_WIDTH = cw_q;
  assign NOISE          = noise_q;
  assign CTRL_ready     = ctrl_ready_q;

endmodule

// File: tb/tb_ecc_apb_slave.sv
// tb_ecc_apb_slave: self-checking bench for ecc_apb_slave.
// Vector tables, a transfer scoreboard, and stall/strobe/reset sequences.
`timescale 1ns/1ps
module tb_ecc_apb_slave;
  localparam int AW  = 32;
  localparam int ADW = 20;
  localparam int DW  = 32;
`ifdef ECC_APB_PSLVERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  // IDLE->SETUP->ACCESS leaves one low-PREADY access cycle.
  localparam int NOSTALL = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] data_out;
  logic [1:0]    num_of_errors;
  logic          operation_done;
  logic [AW-1:0] CTRL;
  logic [AW-1:0] DATA_IN;
  logic [AW-1:0] CODEWORD_WIDTH;
  logic [AW-1:0] NOISE;
  logic          CTRL_ready;

  ecc_apb_slave_if #(
    .AMBA_WORD(AW), .AMBA_ADDR_WIDTH(ADW)
  ) apb ();

  ecc_apb_slave #(
    .AMBA_WORD(AW),
    .AMBA_ADDR_WIDTH(ADW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .apb(apb),
    .data_out(data_out),
    .num_of_errors(num_of_errors),
    .operation_done(operation_done),
    .CTRL(CTRL),
    .DATA_IN(DATA_IN),
    .CODEWORD_WIDTH(CODEWORD_WIDTH),
    .NOISE(NOISE),
    .CTRL_ready(CTRL_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [ADW-1:0] addr;
    logic [AW-1:0] wdata;
    logic [AW-1:0] exp;
    bit            err;
    string         nm;
  } vec_t;

  typedef struct {
    string         nm;
    bit            wr;
    logic [AW-1:0] exp;
    bit            err;
  } sb_t;

  sb_t sb_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int strobe_cnt = 0;
  int strobe_cyc = -1;
  int run = 0;
  int max_run = 0;
  int xfer_cyc = 0;
  int done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (CTRL_ready === 1'b1) begin
      strobe_cnt <= strobe_cnt + 1;
      strobe_cyc <= cyc;
      run        <= run + 1;
      if (run + 1 > max_run) max_run <= run + 1;
    end else begin
      run <= 0;
    end
  end

  task automatic chk(input string nm,
                     input logic [AW-1:0] act,
                     input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit wr,
                              input logic [ADW-1:0] a,
                              input logic [AW-1:0] wd,
                              input logic [AW-1:0] e,
                              input bit er,
                              input string nm);
    vec_t v;
    v.wr = wr; v.addr = a; v.wdata = wd;
    v.exp = e; v.err = er; v.nm = nm;
    return v;
  endfunction

  task automatic apb_xfer(input string nm,
                          input bit wr,
                          input logic [ADW-1:0] a,
                          input logic [AW-1:0] wd,
                          input logic [AW-1:0] exp,
                          input bit err,
                          output int waits);
    sb_t e;
    sb_t g;
    e.nm = nm; e.wr = wr; e.exp = exp; e.err = err;
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    apb.PWRITE = wr; apb.PADDR = a; apb.PWDATA = wd;
    sb_q.push_back(e);
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (apb.PREADY === 1'b1) break;
      waits++;
      if (waits > 200) break;
    end
    if (waits > 200) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: PREADY low %0d cycles, expected high",
               nm, waits);
    end
    xfer_cyc = cyc;
    g = sb_q.pop_front();
    if (!g.wr) chk({g.nm, " rdata"}, apb.PRDATA, g.exp);
    chk({g.nm, " pslverr"}, AW'(apb.PSLVERR), AW'(g.err));
    @(posedge clk); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic check_strobe(input string nm, input int prev);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, " strobe count"}, AW'(strobe_cnt), AW'(prev + 1));
    chk({nm, " strobe cycle"}, AW'(strobe_cyc), AW'(xfer_cyc + 1));
    chk({nm, " strobe width"}, AW'(max_run), 32'd1);
  endtask

  task automatic pulse_done(input logic [DW-1:0] d,
                            input logic [1:0] n);
    @(posedge clk); #1;
    data_out = d; num_of_errors = n; operation_done = 1'b1;
    done_cyc = cyc;
    @(posedge clk); #1;
    operation_done = 1'b0;
  endtask

  initial begin
    vec_t rst_tab[8];
    vec_t rb_tab[6];
    int w;
    int sc;

    for (int i = 0; i < 8; i++) begin
      rst_tab[i] = mk(1'b0, ADW'(i * 4), '0, '0,
                      ERR_EN && (i >= 6),
                      $sformatf("rst_rd_%0h", i * 4));
    end
    rb_tab[0] = mk(1'b0, 20'h00, '0, 32'h1, 1'b0, "rb CTRL");
    rb_tab[1] = mk(1'b0, 20'h04, '0, 32'h1A, 1'b0, "rb DATA_IN");
    rb_tab[2] = mk(1'b0, 20'h08, '0, 32'h1, 1'b0, "rb CW");
    rb_tab[3] = mk(1'b0, 20'h0C, '0, 32'h4, 1'b0, "rb NOISE");
    rb_tab[4] = mk(1'b0, 20'h10, '0, 32'h55, 1'b0, "rb DATA_OUT");
    rb_tab[5] = mk(1'b0, 20'h14, '0, 32'h2, 1'b0, "rb NERR");

    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = '0; apb.PWDATA = '0;
    data_out = '0; num_of_errors = '0; operation_done = 1'b0;
    rst_n = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst PREADY", AW'(apb.PREADY), 32'd0);
    chk("rst PSLVERR", AW'(apb.PSLVERR), 32'd0);
    chk("rst CTRL_ready", AW'(CTRL_ready), 32'd0);
    chk("rst CTRL", CTRL, 32'd0);
    chk("rst PRDATA", apb.PRDATA, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (rst_tab[i]) begin
      apb_xfer(rst_tab[i].nm, rst_tab[i].wr, rst_tab[i].addr,
               rst_tab[i].wdata, rst_tab[i].exp, rst_tab[i].err, w);
      chk({rst_tab[i].nm, " waits"}, AW'(w), AW'(NOSTALL));
    end
    chk("no strobe after reset", AW'(strobe_cnt), 32'd0);

    apb_xfer("wr DATA_IN", 1'b1, 20'h04, 32'h1A, '0, 1'b0, w);
    chk("wr DATA_IN waits", AW'(w), AW'(NOSTALL));
    apb_xfer("wr CW", 1'b1, 20'h08, 32'h1, '0, 1'b0, w);
    sc = strobe_cnt;
    apb_xfer("wr CTRL enc", 1'b1, 20'h00, 32'h0, '0, 1'b0, w);
    check_strobe("enc", sc);
    chk("port DATA_IN", DATA_IN, 32'h1A);
    chk("port CODEWORD_WIDTH", CODEWORD_WIDTH, 32'h1);
    chk("port CTRL", CTRL, 32'h0);

    fork
      apb_xfer("wr NOISE stall", 1'b1, 20'h0C, 32'h4, '0, 1'b0, w);
      begin
        repeat (4) @(posedge clk);
        #1;
        chk("NOISE before done", NOISE, 32'h0);
        pulse_done(32'h3A, 2'b01);
      end
    join
    chk("stall waited", AW'(w > NOSTALL), 32'd1);
    chk("stall release cycle", AW'(xfer_cyc), AW'(done_cyc + 1));
    chk("NOISE after done", NOISE, 32'h4);
    apb_xfer("rd DATA_OUT", 1'b0, 20'h10, '0, 32'h3A, 1'b0, w);
    apb_xfer("rd NERR", 1'b0, 20'h14, '0, 32'h1, 1'b0, w);

    sc = strobe_cnt;
    apb_xfer("wr CTRL dec", 1'b1, 20'h00, 32'h1, '0, 1'b0, w);
    check_strobe("dec", sc);
    apb_xfer("rd busy DATA_IN", 1'b0, 20'h04, '0, 32'h1A, 1'b0, w);
    chk("rd busy waits", AW'(w), AW'(NOSTALL));
    pulse_done(32'h55, 2'b10);

    foreach (rb_tab[i]) begin
      apb_xfer(rb_tab[i].nm, rb_tab[i].wr, rb_tab[i].addr,
               rb_tab[i].wdata, rb_tab[i].exp, rb_tab[i].err, w);
    end

    sc = strobe_cnt;
    apb_xfer("wr CTRL bad", 1'b1, 20'h00, 32'h3, '0, ERR_EN, w);
    chk("wr CTRL bad waits", AW'(w), AW'(NOSTALL));
    repeat (3) @(posedge clk);
    #1;
    chk("bad mode no strobe", AW'(strobe_cnt), AW'(sc));
    chk("bad mode CTRL port", CTRL, 32'h3);
    apb_xfer("wr NOISE idle", 1'b1, 20'h0C, 32'h5, '0, 1'b0, w);
    chk("bad mode not busy", AW'(w), AW'(NOSTALL));
    apb_xfer("wr DATA_OUT ro", 1'b1, 20'h10, 32'hDEAD, '0, ERR_EN, w);
    apb_xfer("rd DATA_OUT kept", 1'b0, 20'h10, '0, 32'h55, 1'b0, w);
    apb_xfer("wr unmapped", 1'b1, 20'h18, 32'h77, '0, ERR_EN, w);
    apb_xfer("rd unmapped", 1'b0, 20'h1C, '0, 32'h0, ERR_EN, w);
    apb_xfer("rd CTRL bad", 1'b0, 20'h00, '0, 32'h3, 1'b0, w);

    sc = strobe_cnt;
    apb_xfer("wr CTRL run", 1'b1, 20'h00, 32'h2, '0, 1'b0, w);
    check_strobe("run", sc);
    apb_xfer("rd pre-reset", 1'b0, 20'h04, '0, 32'h1A, 1'b0, w);
    @(posedge clk); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 20'h0C; apb.PWDATA = 32'h7;
    @(posedge clk); #1;
    apb.PENABLE = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid-stall PREADY", AW'(apb.PREADY), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("async rst CTRL", CTRL, 32'd0);
    chk("async rst DATA_IN", DATA_IN, 32'd0);
    chk("async rst CW", CODEWORD_WIDTH, 32'd0);
    chk("async rst NOISE", NOISE, 32'd0);
    chk("async rst PRDATA", apb.PRDATA, 32'd0);
    chk("async rst PREADY", AW'(apb.PREADY), 32'd0);
    chk("async rst PSLVERR", AW'(apb.PSLVERR), 32'd0);
    chk("async rst CTRL_ready", AW'(CTRL_ready), 32'd0);
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    apb_xfer("post-rst wr NOISE", 1'b1, 20'h0C, 32'h9, '0, 1'b0, w);
    chk("post-rst waits", AW'(w), AW'(NOSTALL));
    apb_xfer("post-rst rd NOISE", 1'b0, 20'h0C, '0, 32'h9, 1'b0, w);
    apb_xfer("post-rst rd CTRL", 1'b0, 20'h00, '0, 32'h0, 1'b0, w);
    apb_xfer("post-rst rd DOUT", 1'b0, 20'h10, '0, 32'h0, 1'b0, w);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ecc_apb_slave.md
Name: ecc_apb_slave

Overview:
- APB slave register bank directly upstream of the ECC controller.
- Decodes APB transfers into the CTRL, DATA_IN, CODEWORD_WIDTH and NOISE registers that feed the controller, and issues the one-cycle CTRL_ready start strobe.
- Captures the controller's data_out and num_of_errors into read-only result registers.
- Inserts APB wait states on writes while an operation is in flight, so the controller's inputs never change mid-operation.

Parameters:
- AMBA_WORD, 32, APB data and register width.
- AMBA_ADDR_WIDTH, 20, PADDR width.
- DATA_WIDTH, 32, width of the controller's data_out, zero-extended into DATA_OUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-low reset.
- PADDR  input  AMBA_ADDR_WIDTH  byte address; only PADDR[4:2] is decoded.
- PSEL  input  1  slave select.
- PENABLE  input  1  APB access phase.
- PWRITE  input  1  1 = write, 0 = read.
- PWDATA  input  AMBA_WORD  write data.
- PRDATA  output  AMBA_WORD  read data, valid while PREADY=1 in the access phase.
- PREADY  output  1  transfer complete.
- PSLVERR  output  1  error response; see Optional Feature.
- data_out  input  DATA_WIDTH  result from the controller.
- num_of_errors  input  2  error count from the controller.
- operation_done  input  1  one-cycle completion pulse from the controller.
- CTRL  output  AMBA_WORD  control register.
- DATA_IN  output  AMBA_WORD  data register.
- CODEWORD_WIDTH  output  AMBA_WORD  codeword width register.
- NOISE  output  AMBA_WORD  noise register.
- CTRL_ready  output  1  one-cycle start strobe to the controller.

Behaviour:
- Register map, decoded on PADDR[4:2]:
  - 0x00 CTRL, read/write.
  - 0x04 DATA_IN, read/write.
  - 0x08 CODEWORD_WIDTH, read/write.
  - 0x0C NOISE, read/write.
  - 0x10 DATA_OUT, read-only.
  - 0x14 NUM_OF_ERRORS, read-only, bits [1:0] valid, upper bits read 0.
  - 0x18 and 0x1C are unmapped and read 0.
- Reset (reset=0, asynchronous): all registers, PRDATA, CTRL_ready, PSLVERR and busy clear to 0. PREADY resets to 0. FSM goes to FULL_IDLE. Reset during a wait-stated transfer abandons that transfer.
- FSM states, 2-bit encoding:
  - FULL_IDLE=00: if PSEL & !PENABLE, go to FULL_SETUP.
  - FULL_SETUP=01: go to FULL_ACCESS.
  - FULL_ACCESS=10: PREADY=1 when the transfer completes. Then go to FULL_SETUP if PSEL & !PENABLE is already presented (back-to-back), else FULL_IDLE.
  - Illegal state 11 goes to FULL_IDLE.
- Reads:
  - PRDATA is registered on entry to FULL_ACCESS from the decoded address.
  - PREADY=1 in the first access cycle; reads never stall, even while busy.
  - PRDATA holds its last value outside access.
- Writes:
  - The register is updated at the clock edge where PSEL & PENABLE & PWRITE & PREADY.
  - If busy=1, PREADY is held 0 and the write is held pending until busy clears; PREADY then asserts in the cycle after the clear.
  - Writes to read-only or unmapped addresses are dropped.
- Start strobe:
  - A completed write to CTRL with PWDATA[1:0] in {00, 01, 10} pulses CTRL_ready high for exactly one cycle, starting the cycle after the write edge, and sets busy at that same edge.
  - PWDATA[1:0]=11 is stored but gives no strobe and busy stays 0.
- Busy:
  - Cleared on the edge where operation_done=1.
  - Same edge: DATA_OUT <= zero-extended data_out, and NUM_OF_ERRORS <= num_of_errors.
  - operation_done while busy=0 still captures the results and is otherwise ignored.
- Simultaneous events:
  - A write to CTRL cannot coincide with operation_done while busy, because writes stall.
  - If operation_done arrives in the same cycle a stalled write is pending, busy clears first. PREADY asserts the next cycle, and a new strobe follows one cycle after that.
- Outputs CTRL, DATA_IN, CODEWORD_WIDTH and NOISE are direct register outputs, stable while busy=1.

Optional Feature:
- Macro ECC_APB_PSLVERR_EN.
- Defined: PSLVERR=1, together with PREADY, on:
  - accesses to unmapped addresses;
  - writes to 0x10 or 0x14;
  - writes to CTRL with PWDATA[1:0]=11. The register still updates, and no strobe is issued.
  - PSLVERR is 0 in all other cycles.
- Undefined: PSLVERR is tied to 0. The same accesses complete silently as described in Behaviour.

Test Plan:
- Reset check: after reset release, read 0x00 through 0x14 -> all return 0x00000000, PSLVERR=0, CTRL_ready never asserted.
- Encode start: write DATA_IN=0x0000001A, CODEWORD_WIDTH=0x1, then CTRL=0x0 -> CTRL_ready high for exactly 1 cycle, one cycle after the CTRL write edge; the output ports show the written values.
- Stall: while busy, write NOISE=0x00000004 -> PREADY stays 0 until a cycle after operation_done. Drive data_out=0x0000003A and num_of_errors=2'b01 with the done pulse -> NOISE updates only after done; reading 0x10 returns 0x0000003A and reading 0x14 returns 0x00000001.
- Read while busy: start a decode with CTRL=0x1, then read 0x04 before done -> PREADY=1 with no wait state, and the previously written DATA_IN is returned.
- Invalid mode and RO write: write CTRL=0x3 -> stored, no CTRL_ready. Write 0x10 -> DATA_OUT unchanged. With ECC_APB_PSLVERR_EN, PSLVERR=1 on both; without it, 0 on both.
- Reset mid-stall: assert reset while a write is stalled -> all outputs clear immediately, FSM in FULL_IDLE, next transfer completes normally.
